// File: rtl/axi_read_arbiter_if.sv
// rtl/axi_read_arbiter_if.sv - request, start and read-beat signals of the read-channel arbiter
interface axi_read_arbiter_if #(
   parameter int ADDR_WIDTH = 64
);
   logic                  i_start_read_instr;
   logic                  i_start_read_data;
   logic [ADDR_WIDTH-1:0] i_addr_instr;
   logic [ADDR_WIDTH-1:0] i_addr_data;
   logic                  i_r_valid;
   logic                  i_r_last;
   logic                  o_start_read_axi;
   logic [ADDR_WIDTH-1:0] o_read_addr;
   logic                  o_grant_instr;
   logic                  o_grant_data;
   logic                  o_r_valid_instr;
   logic                  o_r_valid_data;
   logic                  o_r_last_instr;
   logic                  o_r_last_data;
   logic                  o_busy;
   logic                  o_err;

   modport slave (
      input  i_start_read_instr, i_start_read_data, i_addr_instr, i_addr_data, i_r_valid, i_r_last,
      output o_start_read_axi, o_read_addr, o_grant_instr, o_grant_data, o_r_valid_instr,
             o_r_valid_data, o_r_last_instr, o_r_last_data, o_busy, o_err
   );

   modport master (
      output i_start_read_instr, i_start_read_data, i_addr_instr, i_addr_data, i_r_valid, i_r_last,
      input  o_start_read_axi, o_read_addr, o_grant_instr, o_grant_data, o_r_valid_instr,
             o_r_valid_data, o_r_last_instr, o_r_last_data, o_busy, o_err
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - shares one AXI read channel between the instr and data cache fills
module axi_read_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int BEATS      = 16,
   parameter bit RR_EN      = 1'b0
) (
   input logic               clk,
   input logic               rst,
   axi_read_arbiter_if.slave bus
);
   localparam int CW = $clog2(BEATS + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(BEATS);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t                r_state;
   logic                  r_pend_instr;
   logic                  r_pend_data;
   logic                  r_grant_instr;
   logic                  r_grant_data;
   logic                  r_last_was_data;
   logic                  r_start;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_addr_instr;
   logic [ADDR_WIDTH-1:0] r_addr_data;
   logic [ADDR_WIDTH-1:0] r_addr_issue;
   logic [CW-1:0]         r_beat_cnt;

   logic w_in_wait, w_beat, w_end, w_dup_instr, w_dup_data;
   logic w_pick_data, w_short, w_overrun, w_stray, w_err_now;

   assign w_in_wait   = (r_state == ST_WAIT);
   assign w_beat      = w_in_wait & bus.i_r_valid;
   assign w_end       = w_beat & bus.i_r_last;
   assign w_dup_instr = bus.i_start_read_instr & (r_pend_instr | r_grant_instr);
   assign w_dup_data  = bus.i_start_read_data & (r_pend_data | r_grant_data);
   // A tie goes to data unless round-robin is on and data won the previous grant.
   assign w_pick_data = r_pend_data & (~r_pend_instr | ~RR_EN | ~r_last_was_data);
   assign w_short     = w_end & (r_beat_cnt != LAST_BEAT);
   assign w_overrun   = w_beat & ~bus.i_r_last & (r_beat_cnt == LAST_BEAT);
   assign w_stray     = bus.i_r_valid & ~w_in_wait;
   assign w_err_now   = w_dup_instr | w_dup_data | w_short | w_overrun | w_stray;

   assign bus.o_start_read_axi = r_start;
   assign bus.o_read_addr      = r_start ? r_addr_issue : '0;
   assign bus.o_grant_instr    = r_grant_instr;
   assign bus.o_grant_data     = r_grant_data;
   assign bus.o_r_valid_instr  = w_beat & r_grant_instr;
   assign bus.o_r_valid_data   = w_beat & r_grant_data;
   assign bus.o_r_last_instr   = w_end & r_grant_instr;
   assign bus.o_r_last_data    = w_end & r_grant_data;
   assign bus.o_busy           = (r_state != ST_IDLE) | r_pend_instr | r_pend_data;
   assign bus.o_err            = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_pend_instr    <= 1'b0;
         r_pend_data     <= 1'b0;
         r_grant_instr   <= 1'b0;
         r_grant_data    <= 1'b0;
         r_last_was_data <= 1'b0;
         r_start         <= 1'b0;
         r_err           <= 1'b0;
         r_addr_instr    <= '0;
         r_addr_data     <= '0;
         r_addr_issue    <= '0;
         r_beat_cnt      <= '0;
      end else begin
         r_start <= 1'b0;
         if (w_err_now) r_err <= 1'b1;
         if (bus.i_start_read_instr && !w_dup_instr) begin
            r_pend_instr <= 1'b1;
            r_addr_instr <= bus.i_addr_instr;
         end
         if (bus.i_start_read_data && !w_dup_data) begin
            r_pend_data <= 1'b1;
            r_addr_data <= bus.i_addr_data;
         end
         case (r_state)
            ST_IDLE: begin
               if (r_pend_instr || r_pend_data) begin
                  r_state         <= ST_ISSUE;
                  r_start         <= 1'b1;
                  r_last_was_data <= w_pick_data;
                  r_grant_data    <= w_pick_data;
                  r_grant_instr   <= ~w_pick_data;
                  if (w_pick_data) begin
                     r_pend_data  <= 1'b0;
                     r_addr_issue <= r_addr_data;
                  end else begin
                     r_pend_instr <= 1'b0;
                     r_addr_issue <= r_addr_instr;
                  end
               end
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (w_end) begin
                  r_state       <= ST_IDLE;
                  r_beat_cnt    <= '0;
                  r_grant_instr <= 1'b0;
                  r_grant_data  <= 1'b0;
               end else if (w_beat && r_beat_cnt != FULL_CNT) begin
                  // Saturate so an overlong burst cannot wrap back to a legal count.
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - fixed-priority and round-robin arbiters checked against a burst-level model
module tb_axi_read_arbiter;
   localparam int AW    = 64;
   localparam int BEATS = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start_i = 1'b0, start_d = 1'b0, rv = 1'b0, rl = 1'b0;
   logic [AW-1:0] addr_i = '0, addr_d = '0;

   axi_read_arbiter_if #(.ADDR_WIDTH(AW)) bus0 ();
   axi_read_arbiter_if #(.ADDR_WIDTH(AW)) bus1 ();

   assign bus0.i_start_read_instr = start_i;
   assign bus0.i_start_read_data  = start_d;
   assign bus0.i_addr_instr       = addr_i;
   assign bus0.i_addr_data        = addr_d;
   assign bus0.i_r_valid          = rv;
   assign bus0.i_r_last           = rl;
   assign bus1.i_start_read_instr = start_i;
   assign bus1.i_start_read_data  = start_d;
   assign bus1.i_addr_instr       = addr_i;
   assign bus1.i_addr_data        = addr_d;
   assign bus1.i_r_valid          = rv;
   assign bus1.i_r_last           = rl;

   axi_read_arbiter #(.ADDR_WIDTH(AW), .BEATS(BEATS), .RR_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   axi_read_arbiter #(.ADDR_WIDTH(AW), .BEATS(BEATS), .RR_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // {start, grant_i, grant_d, rvalid_i, rvalid_d, rlast_i, rlast_d, busy, err}
   logic [8:0]    out_f [2];
   logic [AW-1:0] out_a [2];
   assign out_f[0] = {bus0.o_start_read_axi, bus0.o_grant_instr, bus0.o_grant_data, bus0.o_r_valid_instr,
                      bus0.o_r_valid_data, bus0.o_r_last_instr, bus0.o_r_last_data, bus0.o_busy, bus0.o_err};
   assign out_f[1] = {bus1.o_start_read_axi, bus1.o_grant_instr, bus1.o_grant_data, bus1.o_r_valid_instr,
                      bus1.o_r_valid_data, bus1.o_r_last_instr, bus1.o_r_last_data, bus1.o_busy, bus1.o_err};
   assign out_a[0] = bus0.o_read_addr;
   assign out_a[1] = bus1.o_read_addr;

   // Model per arbiter: requester 0 = instr, 1 = data; phase 0 idle, 1 issue, 2 wait.
   bit            m_pend  [2][2];
   logic [AW-1:0] m_paddr [2][2];
   logic [AW-1:0] m_cur   [2];
   int            m_phase [2];
   int            m_owner [2];
   int            m_lastw [2];
   int            m_beats [2];
   bit            m_err   [2];

   int checks = 0, failures = 0;
   int cyc = 0, sent = 0, burst_len = BEATS;
   bit live = 1'b0, beats_on = 1'b1, stray = 1'b0;
   int own0[$], own1[$], scyc0[$], rlcyc0[$];
   logic [AW-1:0] addr0[$];
   int n_rvi0 = 0, n_rvd0 = 0, last_at0 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset(int k);
      for (int r = 0; r < 2; r++) begin
         m_pend[k][r]  = 1'b0;
         m_paddr[k][r] = '0;
      end
      m_cur[k] = '0; m_phase[k] = 0; m_owner[k] = 0; m_lastw[k] = 0; m_beats[k] = 0; m_err[k] = 1'b0;
   endfunction

   function automatic void model_step(int k, bit rr);
      bit            pulse [2];
      logic [AW-1:0] a [2];
      bit            was [2];
      int            w;
      if (rst) begin
         model_reset(k);
         return;
      end
      pulse[0] = start_i; pulse[1] = start_d; a[0] = addr_i; a[1] = addr_d;
      was[0] = m_pend[k][0]; was[1] = m_pend[k][1];
      if (rv && m_phase[k] != 2) m_err[k] = 1'b1;
      for (int r = 0; r < 2; r++) begin
         if (pulse[r]) begin
            if (m_pend[k][r] || (m_phase[k] != 0 && m_owner[k] == r)) m_err[k] = 1'b1;
            else begin
               m_pend[k][r]  = 1'b1;
               m_paddr[k][r] = a[r];
            end
         end
      end
      case (m_phase[k])
         0: if (was[0] || was[1]) begin
            if (was[0] && was[1]) w = rr ? 1 - m_lastw[k] : 1;
            else w = was[1] ? 1 : 0;
            m_owner[k] = w; m_lastw[k] = w; m_pend[k][w] = 1'b0;
            m_cur[k] = m_paddr[k][w]; m_phase[k] = 1;
         end
         1: begin
            m_phase[k] = 2;
            m_beats[k] = 0;
         end
         default: if (rv) begin
            m_beats[k]++;
            if (rl) begin
               if (m_beats[k] != BEATS) m_err[k] = 1'b1;
               m_phase[k] = 0;
            end else if (m_beats[k] == BEATS) m_err[k] = 1'b1;
         end
      endcase
   endfunction

   function automatic logic [8:0] model_flags(int k);
      bit iss, wt, gi, gd, busy;
      iss  = (m_phase[k] == 1);
      wt   = (m_phase[k] == 2);
      gi   = (m_phase[k] != 0) && (m_owner[k] == 0);
      gd   = (m_phase[k] != 0) && (m_owner[k] == 1);
      busy = (m_phase[k] != 0) || m_pend[k][0] || m_pend[k][1];
      return {iss, gi, gd, wt && gi && rv, wt && gd && rv, wt && gi && rv && rl, wt && gd && rv && rl, busy, m_err[k]};
   endfunction

   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("dut%0d_flags", k), 64'(out_f[k]), 64'(model_flags(k)));
         check($sformatf("dut%0d_addr", k), out_a[k], (m_phase[k] == 1) ? m_cur[k] : '0);
      end
      if (out_f[0][8]) begin
         own0.push_back(int'(out_f[0][6]));
         addr0.push_back(out_a[0]);
         scyc0.push_back(cyc);
      end
      if (out_f[1][8]) own1.push_back(int'(out_f[1][6]));
      if (out_f[0][5]) n_rvi0++;
      if (out_f[0][4]) n_rvd0++;
      if (out_f[0][3]) last_at0 = n_rvi0;
      if (out_f[0][3] || out_f[0][2]) rlcyc0.push_back(cyc);
   endtask

   task automatic tick();
      bit was_wait;
      if (stray) begin
         rv = 1'b1; rl = 1'b0;
      end else if (beats_on && m_phase[0] == 2) begin
         rv = ($urandom_range(3) != 0);
         rl = rv && (sent == burst_len - 1);
      end else begin
         rv = 1'b0; rl = 1'b0;
      end
      @(negedge clk);
      if (live) compare();
      @(posedge clk);
      was_wait = (m_phase[0] == 2);
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      cyc++;
      if (rst) sent = 0;
      else if (was_wait && rv) sent = rl ? 0 : sent + 1;
      #1;
      start_i = 1'b0;
      start_d = 1'b0;
   endtask

   task automatic pulse(input bit pi, input bit pd, input logic [AW-1:0] ai, input logic [AW-1:0] ad);
      start_i = pi; start_d = pd; addr_i = ai; addr_d = ad;
      tick();
   endtask

   task automatic run_idle(input int budget);
      int n;
      n = 0;
      while ((m_phase[0] != 0 || m_pend[0][0] || m_pend[0][1] || m_phase[1] != 0 || m_pend[1][0] ||
              m_pend[1][1] || out_f[0][1] || out_f[1][1]) && n < budget) begin
         tick();
         n++;
      end
      check("idle_within_budget", 64'(n < budget), 64'(1));
   endtask

   task automatic do_reset();
      beats_on = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      beats_on = 1'b1;
   endtask

   task automatic clear_logs();
      own0.delete(); own1.delete(); scyc0.delete(); rlcyc0.delete(); addr0.delete();
      n_rvi0 = 0; n_rvd0 = 0; last_at0 = 0;
   endtask

   int p, n, accepted;
   bit ok;

   initial begin
      model_reset(0);
      model_reset(1);
      tick();
      tick();
      live = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_flags0", 64'(out_f[0]), 64'(0));
      check("reset_flags1", 64'(out_f[1]), 64'(0));
      check("reset_addr0", out_a[0], 64'(0));

      // Single instr burst.
      clear_logs();
      p = cyc;
      pulse(1'b1, 1'b0, 64'h1000, 64'h0);
      run_idle(200);
      check("t1_starts", 64'(own0.size()), 64'(1));
      if (addr0.size() > 0) check("t1_addr", addr0[0], 64'h1000);
      if (scyc0.size() > 0) check("t1_latency", 64'(scyc0[0] - p), 64'(2));
      check("t1_beats", 64'(n_rvi0), 64'(16));
      check("t1_last_on_beat", 64'(last_at0), 64'(16));
      check("t1_err", 64'(out_f[0][0]), 64'(0));

      // Simultaneous pulses: data first, one idle cycle, then instr.
      clear_logs();
      pulse(1'b1, 1'b1, 64'h2000, 64'h3000);
      run_idle(300);
      check("t2_starts", 64'(own0.size()), 64'(2));
      if (own0.size() == 2) begin
         check("t2_first_owner", 64'(own0[0]), 64'(1));
         check("t2_second_owner", 64'(own0[1]), 64'(0));
         check("t2_first_addr", addr0[0], 64'h3000);
         check("t2_second_addr", addr0[1], 64'h2000);
      end
      if (scyc0.size() == 2 && rlcyc0.size() > 0) check("t2_gap", 64'(scyc0[1] - rlcyc0[0]), 64'(2));

      // Round-robin with both requesters re-pulsing after every burst.
      clear_logs();
      pulse(1'b1, 1'b1, 64'h4000, 64'h5000);
      for (int b = 0; b < 3; b++) begin
         n = 0;
         while (m_phase[1] != 2 && n < 100) begin tick(); n++; end
         while (m_phase[1] == 2 && n < 100) begin tick(); n++; end
         check("t3_burst_ended", 64'(n < 100), 64'(1));
         pulse(m_owner[1] == 0, m_owner[1] == 1, 64'(32'h4100 + b), 64'(32'h5100 + b));
      end
      run_idle(400);
      check("t3_bursts", 64'(own1.size()), 64'(5));
      if (own1.size() >= 4) begin
         check("t3_g0", 64'(own1[0]), 64'(1));
         check("t3_g1", 64'(own1[1]), 64'(0));
         check("t3_g2", 64'(own1[2]), 64'(1));
         check("t3_g3", 64'(own1[3]), 64'(0));
      end
      clear_logs();
      pulse(1'b0, 1'b1, 64'h0, 64'h5800);
      run_idle(200);
      clear_logs();
      pulse(1'b1, 1'b1, 64'h4800, 64'h5900);
      run_idle(300);
      if (own0.size() == 2 && own1.size() == 2) begin
         check("t3_fixed_tie", 64'(own0[0]), 64'(1));
         check("t3_rr_tie", 64'(own1[0]), 64'(0));
      end else check("t3_tie_bursts", 64'(own0.size() + own1.size()), 64'(4));

      // Random legal traffic; every accepted pulse must produce exactly one burst.
      clear_logs();
      accepted = 0;
      for (int t = 0; t < 1500; t++) begin
         for (int r = 0; r < 2; r++) begin
            ok = ($urandom_range(7) == 0);
            for (int k = 0; k < 2; k++)
               if (m_pend[k][r] || (m_phase[k] != 0 && m_owner[k] == r)) ok = 1'b0;
            if (ok) begin
               accepted++;
               if (r == 0) begin start_i = 1'b1; addr_i = {$urandom, $urandom}; end
               else begin start_d = 1'b1; addr_d = {$urandom, $urandom}; end
            end
         end
         tick();
      end
      run_idle(600);
      check("rand_bursts0", 64'(own0.size()), 64'(accepted));
      check("rand_bursts1", 64'(own1.size()), 64'(accepted));
      check("rand_err", 64'(out_f[0][0] | out_f[1][0]), 64'(0));

      // Short burst: r_last on beat 10.
      clear_logs();
      burst_len = 10;
      pulse(1'b1, 1'b1, 64'h6000, 64'h7000);
      n = 0;
      while (m_phase[0] != 2 && n < 100) begin tick(); n++; end
      while (m_phase[0] == 2 && n < 100) begin tick(); n++; end
      burst_len = BEATS;
      run_idle(300);
      check("t4_data_beats", 64'(n_rvd0), 64'(10));
      check("t4_next_burst", 64'(own0.size()), 64'(2));
      check("t4_instr_last", 64'(last_at0), 64'(16));
      check("t4_err", 64'(out_f[0][0]), 64'(1));

      // Reset in the middle of a burst, then a clean burst.
      do_reset();
      clear_logs();
      pulse(1'b1, 1'b0, 64'h8000, 64'h0);
      n = 0;
      while (sent < 5 && n < 100) begin tick(); n++; end
      do_reset();
      check("t5_flags0", 64'(out_f[0]), 64'(0));
      check("t5_flags1", 64'(out_f[1]), 64'(0));
      clear_logs();
      pulse(1'b1, 1'b0, 64'h9000, 64'h0);
      run_idle(200);
      check("t5_starts", 64'(own0.size()), 64'(1));
      if (addr0.size() > 0) check("t5_addr", addr0[0], 64'h9000);
      check("t5_beats", 64'(n_rvi0), 64'(16));
      check("t5_err", 64'(out_f[0][0]), 64'(0));

      // Stray beat while idle, then a repeat pulse while granted.
      clear_logs();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      check("t6_stray_steered", 64'(n_rvi0 + n_rvd0), 64'(0));
      check("t6_stray_err", 64'(out_f[0][0]), 64'(1));
      do_reset();
      clear_logs();
      pulse(1'b1, 1'b0, 64'hA000, 64'h0);
      n = 0;
      while (m_phase[0] != 2 && n < 20) begin tick(); n++; end
      pulse(1'b1, 1'b0, 64'hB000, 64'h0);
      run_idle(200);
      check("t6_dup_ignored", 64'(own0.size()), 64'(1));
      check("t6_dup_err", 64'(out_f[0][0]), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
